// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the accumulator CPU sequencer: FSM state encoding,
// ALU opcode values and the instruction word layout.
package cpu_sequencer_pkg;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FETCH     = 3'd1;
    localparam logic [2:0] ST_DECODE    = 3'd2;
    localparam logic [2:0] ST_EXECUTE   = 3'd3;
    localparam logic [2:0] ST_WRITEBACK = 3'd4;
    localparam logic [2:0] ST_HALT      = 3'd5;

    // ALU opcodes, forwarded unchanged on alu_sel
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_MUL = 3'd5;
    localparam logic [2:0] ALU_DIV = 3'd6;
    localparam logic [2:0] ALU_CMP = 3'd7;

    // Instruction word field positions
    localparam int INSTR_HALT_BIT = 15;
    localparam int INSTR_RSV_MSB  = 14;
    localparam int INSTR_RSV_LSB  = 11;
    localparam int INSTR_OP_MSB   = 10;
    localparam int INSTR_OP_LSB   = 8;
    localparam int INSTR_IMM_MSB  = 7;
    localparam int INSTR_IMM_LSB  = 0;

    // Same layout as a packed struct, handy for building instruction words
    typedef struct packed {
        logic       halt;
        logic [3:0] rsv;
        logic [2:0] op;
        logic [7:0] imm;
    } instr_t;

endpackage

// File: rtl/cpu_sequencer.sv
// Multi-cycle accumulator CPU control: fetches 16-bit instructions, drives an
// external ALU with {acc, imm8, opcode} and writes the result back into acc.
// Each non-halt instruction runs FETCH -> DECODE -> EXECUTE -> WRITEBACK.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter logic [7:0] ACC_INIT = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [7:0]  imem_addr,
    output logic        imem_rd,
    input  logic [15:0] imem_data,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_sel,
    input  logic [7:0]  alu_out,
    input  logic        carry_out,
    output logic [7:0]  acc,
    output logic        carry,
    output logic        busy,
    output logic        done
);

    logic [2:0] r_state;
    logic [2:0] w_state_next;
    logic [7:0] r_pc;
    logic [7:0] r_acc;
    logic       r_carry;
    // Instruction register: only the fields that outlive DECODE are kept.
    // They double as the ALU operand registers, so they are loaded only for
    // non-halt instructions and otherwise hold their last value.
    logic [7:0] r_alu_a;
    logic [7:0] r_ir_imm;
    logic [2:0] r_ir_op;

    logic       w_is_halt;
    logic       w_unused_rsv;

    assign w_is_halt    = imem_data[INSTR_HALT_BIT];
    // Reserved bits carry no meaning; they are deliberately ignored.
    assign w_unused_rsv = ^imem_data[INSTR_RSV_MSB:INSTR_RSV_LSB];

    // Next-state decode; start is only honoured from IDLE and HALT
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:      if (start) w_state_next = ST_FETCH;
            ST_FETCH:     w_state_next = ST_DECODE;
            ST_DECODE:    w_state_next = w_is_halt ? ST_HALT : ST_EXECUTE;
            ST_EXECUTE:   w_state_next = ST_WRITEBACK;
            ST_WRITEBACK: w_state_next = ST_FETCH;
            ST_HALT:      if (start) w_state_next = ST_FETCH;
            default:      w_state_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath registers: pc, accumulator, carry and latched ALU operands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_acc    <= ACC_INIT;
            r_carry  <= 1'b0;
            r_alu_a  <= 8'h00;
            r_ir_imm <= 8'h00;
            r_ir_op  <= 3'd0;
        end else begin
            case (r_state)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        r_pc    <= RESET_PC;
                        r_acc   <= ACC_INIT;
                        r_carry <= 1'b0;
                    end
                end
                ST_DECODE: begin
                    // Operands are captured here so they are already stable
                    // on the first EXECUTE cycle and through WRITEBACK.
                    if (!w_is_halt) begin
                        r_alu_a  <= r_acc;
                        r_ir_imm <= imem_data[INSTR_IMM_MSB:INSTR_IMM_LSB];
                        r_ir_op  <= imem_data[INSTR_OP_MSB:INSTR_OP_LSB];
                    end
                end
                ST_WRITEBACK: begin
                    // pc wraps naturally from 8'hFF to 8'h00
                    r_acc   <= alu_out;
                    r_carry <= carry_out;
                    r_pc    <= r_pc + 8'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign imem_addr = r_pc;
    assign imem_rd   = (r_state == ST_FETCH);
    assign alu_a     = r_alu_a;
    assign alu_b     = r_ir_imm;
    assign alu_sel   = r_ir_op;
    assign acc       = r_acc;
    assign carry     = r_carry;
    assign busy      = (r_state != ST_IDLE) && (r_state != ST_HALT);
    assign done      = (r_state == ST_HALT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Testbench for cpu_sequencer: two instances (default parameters, and
// RESET_PC=8'hFE / ACC_INIT=8'hF0), each with its own instruction memory
// and ALU model. Table-driven two-instruction programs plus hand sequences
// for timing, busy-start, wrap, async reset and restart.
module tb_cpu_sequencer;
    import cpu_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- instance 1: default parameters ----------------
    logic        start1 = 1'b0;
    logic [7:0]  imem_addr1;
    logic        imem_rd1;
    logic [15:0] imem_data1 = 16'h0000;
    logic [7:0]  alu_a1, alu_b1, alu_out1, acc1;
    logic [2:0]  alu_sel1;
    logic        carry_out1, carry1, busy1, done1;
    logic [15:0] mem1 [256];

    cpu_sequencer u_dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .imem_addr(imem_addr1), .imem_rd(imem_rd1), .imem_data(imem_data1),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_sel(alu_sel1),
        .alu_out(alu_out1), .carry_out(carry_out1),
        .acc(acc1), .carry(carry1), .busy(busy1), .done(done1)
    );

    // ---------------- instance 2: non-zero reset values ----------------
    logic        start2 = 1'b0;
    logic [7:0]  imem_addr2;
    logic        imem_rd2;
    logic [15:0] imem_data2 = 16'h0000;
    logic [7:0]  alu_a2, alu_b2, alu_out2, acc2;
    logic [2:0]  alu_sel2;
    logic        carry_out2, carry2, busy2, done2;
    logic [15:0] mem2 [256];

    cpu_sequencer #(.RESET_PC(8'hFE), .ACC_INIT(8'hF0)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .imem_addr(imem_addr2), .imem_rd(imem_rd2), .imem_data(imem_data2),
        .alu_a(alu_a2), .alu_b(alu_b2), .alu_sel(alu_sel2),
        .alu_out(alu_out2), .carry_out(carry_out2),
        .acc(acc2), .carry(carry2), .busy(busy2), .done(done2)
    );

    // Instruction memories: data valid the cycle after imem_rd
    always @(posedge clk) begin
        if (imem_rd1) imem_data1 <= mem1[imem_addr1];
        if (imem_rd2) imem_data2 <= mem2[imem_addr2];
    end

    // Behavioural ALU: returns {carry, result}
    function automatic logic [8:0] alu_f(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        case (sel)
            ALU_ADD: alu_f = {1'b0, a} + {1'b0, b};
            ALU_SUB: alu_f = {(a < b), a - b};
            ALU_AND: alu_f = {1'b0, a & b};
            ALU_OR:  alu_f = {1'b0, a | b};
            ALU_XOR: alu_f = {1'b0, a ^ b};
            ALU_MUL: alu_f = {(|p[15:8]), p[7:0]};
            ALU_DIV: alu_f = (b == 8'h00) ? 9'h100 : {1'b0, a / b};
            default: alu_f = {(a < b), a};
        endcase
    endfunction

    assign {carry_out1, alu_out1} = alu_f(alu_sel1, alu_a1, alu_b1);
    assign {carry_out2, alu_out2} = alu_f(alu_sel2, alu_a2, alu_b2);

    function automatic logic [15:0] ins(input logic [3:0] rsv, input logic [2:0] op, input logic [7:0] imm);
        ins = {1'b0, rsv, op, imm};
    endfunction

    localparam logic [15:0] HALT_W = 16'h8000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Pulse start for one clock; returns at the negedge of the first FETCH cycle
    task automatic pulse_start(input int which);
        @(negedge clk);
        if (which == 1) start1 = 1'b1; else start2 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic wait_done(input int which, input int budget);
        int n;
        n = 0;
        while (((which == 1) ? done1 : done2) !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("dut%0d_done_reached", which), (which == 1) ? done1 : done2, 1);
    endtask

    // Runs {ADD 5, ADD 3, HALT} sampling every cycle; optionally pulses start while busy
    task automatic run_timed(input bit noisy, input string tag);
        logic [10:0] rd_bits, done_bits, busy_bits;
        logic [31:0] ops;
        mem1[0] = ins(4'h0, ALU_ADD, 8'h05);
        mem1[1] = ins(4'h0, ALU_ADD, 8'h03);
        mem1[2] = HALT_W;
        ops = 32'h0;
        pulse_start(1);
        for (int k = 0; k <= 10; k++) begin
            rd_bits[k]   = imem_rd1;
            done_bits[k] = done1;
            busy_bits[k] = busy1;
            if (k == 2) ops[31:24] = alu_b1;
            if (k == 3) ops[23:16] = alu_b1;
            if (k == 6) ops[15:8]  = alu_a1;
            if (k == 7) ops[7:0]   = alu_b1;
            start1 = noisy && (k == 1 || k == 5 || k == 9);
            @(negedge clk);
        end
        start1 = 1'b0;
        check({tag, "_imem_rd_pattern"}, rd_bits, 11'h111);
        check({tag, "_done_pattern"}, done_bits, 11'h400);
        check({tag, "_busy_pattern"}, busy_bits, 11'h3FF);
        check({tag, "_operands"}, ops, 32'h0505_0503);
        check({tag, "_acc"}, acc1, 8'h08);
        check({tag, "_carry"}, carry1, 1'b0);
        check({tag, "_pc"}, imem_addr1, 8'h02);
    endtask

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] rsv;
        logic [7:0] exp_acc;
        logic       exp_c;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic seen;

        vecs[0] = '{ALU_ADD, 8'h05, 8'h03, 4'h0, 8'h08, 1'b0};
        vecs[1] = '{ALU_ADD, 8'hF0, 8'h20, 4'h0, 8'h10, 1'b1};
        vecs[2] = '{ALU_SUB, 8'h0F, 8'h10, 4'h0, 8'hFF, 1'b1};
        vecs[3] = '{ALU_AND, 8'hAA, 8'h0F, 4'hF, 8'h0A, 1'b0};
        vecs[4] = '{ALU_OR,  8'hA0, 8'h05, 4'h5, 8'hA5, 1'b0};
        vecs[5] = '{ALU_XOR, 8'hFF, 8'h0F, 4'h0, 8'hF0, 1'b0};
        vecs[6] = '{ALU_MUL, 8'h10, 8'h11, 4'h0, 8'h10, 1'b1};
        vecs[7] = '{ALU_DIV, 8'h64, 8'h07, 4'h0, 8'h0E, 1'b0};
        vecs[8] = '{ALU_DIV, 8'h00, 8'h00, 4'h0, 8'h00, 1'b1};
        vecs[9] = '{ALU_CMP, 8'h05, 8'h09, 4'h0, 8'h05, 1'b1};

        for (int i = 0; i < 256; i++) begin
            mem1[i] = 16'h0000;
            mem2[i] = 16'h0000;
        end

        // Reset state and no fetch before start
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | imem_rd1 | imem_rd2 | busy1 | busy2;
        end
        check("idle_no_fetch", seen, 1'b0);
        check("rst1_pc", imem_addr1, 8'h00);
        check("rst1_acc", acc1, 8'h00);
        check("rst1_flags", {carry1, busy1, done1}, 3'b000);
        check("rst1_alu", {alu_a1, alu_b1, alu_sel1}, 19'h0);
        check("rst2_pc", imem_addr2, 8'hFE);
        check("rst2_acc", acc2, 8'hF0);
        check("rst2_flags", {carry2, busy2, done2}, 3'b000);

        // Cycle-accurate timing, then the same program with start pulsed while busy
        run_timed(1'b0, "timed");
        run_timed(1'b1, "busy_start");

        // Table: ADD a ; op b ; HALT
        for (int i = 0; i < 10; i++) begin
            mem1[0] = ins(4'h0, ALU_ADD, vecs[i].a);
            mem1[1] = ins(vecs[i].rsv, vecs[i].op, vecs[i].b);
            mem1[2] = HALT_W;
            pulse_start(1);
            wait_done(1, 40);
            check($sformatf("vec%0d_acc", i), acc1, vecs[i].exp_acc);
            check($sformatf("vec%0d_carry", i), carry1, vecs[i].exp_c);
            check($sformatf("vec%0d_pc", i), imem_addr1, 8'h02);
            check($sformatf("vec%0d_alu_hold", i), {alu_a1, alu_b1, alu_sel1},
                  {vecs[i].a, vecs[i].b, vecs[i].op});
        end

        // DIV 0 sets carry, following AND FF clears it
        mem1[0] = ins(4'h0, ALU_DIV, 8'h00);
        mem1[1] = ins(4'h0, ALU_AND, 8'hFF);
        mem1[2] = HALT_W;
        pulse_start(1);
        repeat (4) @(negedge clk);
        check("div0_carry", carry1, 1'b1);
        check("div0_acc", acc1, 8'h00);
        wait_done(1, 40);
        check("and_after_div_carry", carry1, 1'b0);
        check("and_after_div_acc", acc1, 8'h00);

        // Second instance: ACC_INIT=F0, ADD 20 from pc FE, then HALT at FF
        mem2[8'hFE] = ins(4'h0, ALU_ADD, 8'h20);
        mem2[8'hFF] = HALT_W;
        pulse_start(2);
        wait_done(2, 40);
        check("init_f0_acc", acc2, 8'h10);
        check("init_f0_carry", carry2, 1'b1);
        check("init_f0_pc", imem_addr2, 8'hFF);
        // Restart from HALT re-initialises and runs across the pc wrap
        mem2[8'hFE] = ins(4'h0, ALU_ADD, 8'h01);
        mem2[8'hFF] = ins(4'h0, ALU_ADD, 8'h01);
        mem2[8'h00] = HALT_W;
        pulse_start(2);
        check("restart2_pc", imem_addr2, 8'hFE);
        check("restart2_acc", acc2, 8'hF0);
        wait_done(2, 40);
        check("wrap2_acc", acc2, 8'hF2);
        check("wrap2_carry", carry2, 1'b0);
        check("wrap2_pc", imem_addr2, 8'h00);

        // Asynchronous reset in the middle of EXECUTE
        mem1[0] = ins(4'h0, ALU_ADD, 8'h05);
        mem1[1] = ins(4'h0, ALU_ADD, 8'h03);
        mem1[2] = HALT_W;
        pulse_start(1);
        repeat (6) @(negedge clk);
        check("pre_rst_exec", {busy1, alu_a1, alu_b1, imem_addr1}, {1'b1, 8'h05, 8'h03, 8'h01});
        #2 rst = 1'b1;
        #1;
        check("async_rst_pc", imem_addr1, 8'h00);
        check("async_rst_acc", acc1, 8'h00);
        check("async_rst_flags", {carry1, busy1, done1, imem_rd1}, 4'b0000);
        check("async_rst_alu", {alu_a1, alu_b1, alu_sel1}, 19'h0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen = seen | imem_rd1 | busy1;
        end
        check("post_rst_idle", seen, 1'b0);
        pulse_start(1);
        wait_done(1, 40);
        check("post_rst_run_acc", acc1, 8'h08);

        // 256 x ADD 1 with no halt: pc wraps and acc returns to 0
        for (int i = 0; i < 256; i++) mem1[i] = ins(4'h0, ALU_ADD, 8'h01);
        pulse_start(1);
        repeat (512) @(negedge clk);
        check("wrap_mid", {imem_rd1, imem_addr1, acc1}, {1'b1, 8'h80, 8'h80});
        repeat (508) @(negedge clk);
        check("wrap_last_pc", {imem_rd1, imem_addr1, acc1}, {1'b1, 8'hFF, 8'hFF});
        repeat (4) @(negedge clk);
        check("wrap_pc", {imem_rd1, imem_addr1}, {1'b1, 8'h00});
        check("wrap_acc", acc1, 8'h00);
        check("wrap_carry", carry1, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
